// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: major opcodes and the immediate-format
// classification used by the decode stage and its immediate generator.
package rv_pkg;

   localparam logic [6:0] OP_LOAD     = 7'h03;
   localparam logic [6:0] OP_STORE    = 7'h23;
   localparam logic [6:0] OP_BRANCH   = 7'h63;
   localparam logic [6:0] OP_JAL      = 7'h6F;
   localparam logic [6:0] OP_JALR     = 7'h67;
   localparam logic [6:0] OP_LUI      = 7'h37;
   localparam logic [6:0] OP_AUIPC    = 7'h17;
   localparam logic [6:0] OP_OP       = 7'h33;
   localparam logic [6:0] OP_OPIMM    = 7'h13;
   localparam logic [6:0] OP_MISC_MEM = 7'h0F;
   localparam logic [6:0] OP_SYSTEM   = 7'h73;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
      imm_fmt_e fmt;
      case (opcode)
         OP_LOAD, OP_OPIMM, OP_JALR: fmt = IMM_I;
         OP_STORE:                   fmt = IMM_S;
         OP_BRANCH:                  fmt = IMM_B;
         OP_LUI, OP_AUIPC:           fmt = IMM_U;
         OP_JAL:                     fmt = IMM_J;
         default:                    fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects the immediate layout from
// the opcode and sign-extends it to XLEN.
module imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm
);

   logic [31:0] raw;

   // NOTE: every variable written in a combinational block gets a default first,
   // otherwise an unassigned path infers a latch.
   always_comb begin
      raw = '0;
      case (imm_fmt_of(inst[6:0]))
         IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   raw = {inst[31:12], 12'b0};
         IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: raw = '0;
      endcase
   end

   // raw already carries the sign in bit 31; widen it for XLEN > 32.
   assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: splits fields, registers the ID/EX bundle,
// inserts load-use bubbles and honours flushes. Optional: ID_ILLEGAL_DETECT_EN.
module id_decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_AW       = 5,
   parameter int BUBBLE_CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_inst,
   input  logic [XLEN-1:0]         in_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [REG_AW-1:0]       out_rs1,
   output logic [REG_AW-1:0]       out_rs2,
   output logic [REG_AW-1:0]       out_rd,
   output logic [6:0]              out_opcode,
   output logic [2:0]              out_funct3,
   output logic [6:0]              out_funct7,
   output logic [XLEN-1:0]         out_imm,
   output logic                    out_rs1_used,
   output logic                    out_rs2_used,
   output logic                    out_rd_we,
   output logic                    out_is_load,
`ifdef ID_ILLEGAL_DETECT_EN
   output logic                    out_illegal,
`endif
   output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

   logic [6:0]        opcode_in;
   logic [2:0]        funct3_in;
   logic [6:0]        funct7_in;
   logic [REG_AW-1:0] rs1_in;
   logic [REG_AW-1:0] rs2_in;
   logic [REG_AW-1:0] rd_in;
   logic [XLEN-1:0]   imm_in;
   logic              rs1_used_raw;
   logic              rs2_used_raw;
   logic              rd_we_raw;
   logic              illegal_in;
   logic              rs1_used_in;
   logic              rs2_used_in;
   logic              rd_we_in;
   logic              is_load_in;

   assign opcode_in = in_inst[6:0];
   assign funct3_in = in_inst[14:12];
   assign funct7_in = in_inst[31:25];
   assign rs1_in    = in_inst[15 +: REG_AW];
   assign rs2_in    = in_inst[20 +: REG_AW];
   assign rd_in     = in_inst[7 +: REG_AW];

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .inst (in_inst),
      .imm  (imm_in)
   );

   always_comb begin
      rs1_used_raw = 1'b1;
      rs2_used_raw = 1'b0;
      rd_we_raw    = 1'b0;
      case (opcode_in)
         OP_LUI, OP_AUIPC, OP_JAL: rs1_used_raw = 1'b0;
         default:                  rs1_used_raw = 1'b1;
      endcase
      case (opcode_in)
         OP_OP, OP_STORE, OP_BRANCH: rs2_used_raw = 1'b1;
         default:                    rs2_used_raw = 1'b0;
      endcase
      case (opcode_in)
         OP_OP, OP_OPIMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: rd_we_raw = (rd_in != '0);
         default:                                                     rd_we_raw = 1'b0;
      endcase
   end

`ifdef ID_ILLEGAL_DETECT_EN
   logic is_shift_imm;

   assign is_shift_imm = (opcode_in == OP_OPIMM) && (funct3_in == 3'b001 || funct3_in == 3'b101);

   always_comb begin
      illegal_in = (in_inst[1:0] != 2'b11);
      case (opcode_in)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
         OP_OP, OP_OPIMM, OP_MISC_MEM, OP_SYSTEM: ;
         default: illegal_in = 1'b1;
      endcase
      if ((opcode_in == OP_OP || is_shift_imm) && funct7_in != 7'h00 && funct7_in != 7'h20)
         illegal_in = 1'b1;
   end
`else
   assign illegal_in = 1'b0;
`endif

   // An illegal instruction flows down the pipe but must not touch the register file.
   assign rs1_used_in = rs1_used_raw && !illegal_in;
   assign rs2_used_in = rs2_used_raw && !illegal_in;
   assign rd_we_in    = rd_we_raw && !illegal_in;
   assign is_load_in  = (opcode_in == OP_LOAD);

   logic                    valid_q, valid_d;
   logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic                    load_en;
   logic [XLEN-1:0]         pc_q;
   logic [REG_AW-1:0]       rs1_q, rs2_q, rd_q;
   logic [6:0]              opcode_q;
   logic [2:0]              funct3_q;
   logic [6:0]              funct7_q;
   logic [XLEN-1:0]         imm_q;
   logic                    rs1_used_q, rs2_used_q, rd_we_q, is_load_q;
   logic                    illegal_q;
   logic                    advance;
   logic                    hazard;

   assign advance = !valid_q || out_ready;
   assign hazard  = valid_q && is_load_q && (rd_q != '0) && in_valid &&
                    ((rs1_used_in && rs1_in == rd_q) || (rs2_used_in && rs2_in == rd_q));
   assign in_ready = rst_n && advance && !hazard && !flush;

   always_comb begin
      valid_d      = valid_q;
      bubble_cnt_d = bubble_cnt_q;
      load_en      = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
      end else if (hazard && advance) begin
         valid_d = 1'b0;
         if (bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_W'(1);
      end else if (in_valid && in_ready) begin
         valid_d = 1'b1;
         load_en = 1'b1;
      end else if (advance) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // NOTE: the bundle registers are reset as well, so the ID/EX boundary
   // presents all-zero data out of reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         opcode_q   <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         imm_q      <= '0;
         rs1_used_q <= 1'b0;
         rs2_used_q <= 1'b0;
         rd_we_q    <= 1'b0;
         is_load_q  <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (load_en) begin
         pc_q       <= in_pc;
         rs1_q      <= rs1_in;
         rs2_q      <= rs2_in;
         rd_q       <= rd_in;
         opcode_q   <= opcode_in;
         funct3_q   <= funct3_in;
         funct7_q   <= funct7_in;
         imm_q      <= imm_in;
         rs1_used_q <= rs1_used_in;
         rs2_used_q <= rs2_used_in;
         rd_we_q    <= rd_we_in;
         is_load_q  <= is_load_in;
         illegal_q  <= illegal_in;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_rs1      = rs1_q;
   assign out_rs2      = rs2_q;
   assign out_rd       = rd_q;
   assign out_opcode   = opcode_q;
   assign out_funct3   = funct3_q;
   assign out_funct7   = funct7_q;
   assign out_imm      = imm_q;
   assign out_rs1_used = rs1_used_q;
   assign out_rs2_used = rs2_used_q;
   assign out_rd_we    = rd_we_q;
   assign out_is_load  = is_load_q;
   assign bubble_cnt   = bubble_cnt_q;

`ifdef ID_ILLEGAL_DETECT_EN
   assign out_illegal = illegal_q;
`else
   logic unused_illegal;
   assign unused_illegal = illegal_q;
`endif

endmodule
